// File: rtl/csr_requester.sv
// ============================================================================
// Module   : csr_requester
// Purpose  : Sequences core CSR/MRET/trap requests onto a CSR responder port,
//            converts faulting CSR instructions into illegal-instruction traps.
// Revision : 1.0
// ============================================================================
`default_nettype none

module csr_requester #(
    parameter int          WATCHDOG_CYCLES = 8,
    parameter logic [3:0]  ILLEGAL_CODE    = 4'd2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_kind,
    input  logic [1:0]  req_csr_op,
    input  logic [11:0] req_csr_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    input  logic [3:0]  req_irq_code,
    output logic        rsp_valid,
    output logic        rsp_rd_we,
    output logic [31:0] rsp_rd_value,
    output logic        rsp_redirect,
    output logic [31:0] rsp_next_pc,
    output logic        rsp_trapped,
    output logic        err,
    output logic        csr_available,
    output logic [2:0]  csr_op,
    output logic [11:0] csr_addr_exception,
    output logic [31:0] csr_write_value,
    input  logic [31:0] csr_read_value,
    input  logic        csr_busy,
    input  logic        csr_fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_REL  = 2'd3
    } state_t;

    localparam int                    c_WDOG_W    = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [c_WDOG_W-1:0]   c_WDOG_LAST = c_WDOG_W'(WATCHDOG_CYCLES - 1);
    localparam logic [c_WDOG_W-1:0]   c_WDOG_ONE  = c_WDOG_W'(1);
    localparam logic [11:0]           c_ILL_ADDR  = {8'b0, ILLEGAL_CODE};

    state_t                r_state;
    logic [31:0]           r_pc;
    logic                  r_retry;
    logic [c_WDOG_W-1:0]   r_wdog;

    logic [2:0]            w_op;
    logic [11:0]           w_addr;
    logic [31:0]           w_value;
    logic [31:0]           w_trap_pc;

    // Undefined kinds and CSR op 00 fall through to the illegal-trap defaults.
    always_comb begin
        w_op    = 3'b000;
        w_addr  = c_ILL_ADDR;
        w_value = req_pc;
        case (req_kind)
            3'b000: begin
                if (req_csr_op != 2'b00) begin
                    w_op    = {1'b1, req_csr_op};
                    w_addr  = req_csr_addr;
                    w_value = req_wdata;
                end
            end
            3'b001: begin
                w_op    = 3'b001;
                w_addr  = 12'h000;
                w_value = 32'h0;
            end
            3'b010:  w_addr = 12'h00B;
            3'b011:  w_addr = 12'h003;
            3'b100:  w_addr = {7'b0, 1'b1, req_irq_code};
            default: ;
        endcase
    end

    assign w_trap_pc = {csr_read_value[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state            <= S_IDLE;
            r_pc               <= 32'h0;
            r_retry            <= 1'b0;
            r_wdog             <= '0;
            req_ready          <= 1'b1;
            rsp_valid          <= 1'b0;
            rsp_rd_we          <= 1'b0;
            rsp_rd_value       <= 32'h0;
            rsp_redirect       <= 1'b0;
            rsp_next_pc        <= 32'h0;
            rsp_trapped        <= 1'b0;
            err                <= 1'b0;
            csr_available      <= 1'b0;
            csr_op             <= 3'b000;
            csr_addr_exception <= 12'h000;
            csr_write_value    <= 32'h0;
        end else begin
            rsp_valid    <= 1'b0;
            rsp_rd_we    <= 1'b0;
            rsp_redirect <= 1'b0;
            rsp_trapped  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        csr_op             <= w_op;
                        csr_addr_exception <= w_addr;
                        csr_write_value    <= w_value;
                        r_pc               <= req_pc;
                        r_retry            <= 1'b0;
                        r_wdog             <= '0;
                        csr_available      <= 1'b1;
                        req_ready          <= 1'b0;
                        r_state            <= S_REQ;
                    end
                end
                S_REQ, S_WAIT: begin
                    if ((r_state == S_REQ) && csr_busy) begin
                        r_wdog  <= '0;
                        r_state <= S_WAIT;
                    end else if ((r_state == S_WAIT) && !csr_busy) begin
                        csr_available <= 1'b0;
                        r_state       <= S_REL;
                        if (csr_op[2] && csr_fault) begin
                            r_retry <= 1'b1;
                        end else begin
                            rsp_valid <= 1'b1;
                            if (csr_op[2]) begin
                                rsp_rd_we    <= 1'b1;
                                rsp_rd_value <= csr_read_value;
                                rsp_next_pc  <= r_pc + 32'd4;
                            end else begin
                                // MRET and traps are never retried; a fault only flags err.
                                rsp_rd_value <= 32'h0;
                                rsp_redirect <= 1'b1;
                                rsp_next_pc  <= w_trap_pc;
                                rsp_trapped  <= (csr_op != 3'b001);
                                if (csr_fault) begin
                                    err <= 1'b1;
                                end
                            end
                        end
                    end else if (r_wdog == c_WDOG_LAST) begin
                        err           <= 1'b1;
                        csr_available <= 1'b0;
                        req_ready     <= 1'b1;
                        r_retry       <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + c_WDOG_ONE;
                    end
                end
                S_REL: begin
                    if (r_retry) begin
                        csr_op             <= 3'b000;
                        csr_addr_exception <= c_ILL_ADDR;
                        csr_write_value    <= r_pc;
                        r_retry            <= 1'b0;
                        r_wdog             <= '0;
                        csr_available      <= 1'b1;
                        r_state            <= S_REQ;
                    end else begin
                        req_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    csr_available <= 1'b0;
                    req_ready     <= 1'b1;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_csr_requester.sv
// ============================================================================
// Module   : tb_csr_requester
// Purpose  : Scoreboard bench for csr_requester with a one-cycle-busy responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_csr_requester;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_kind = 3'b000;
    logic [1:0]  req_csr_op = 2'b00;
    logic [11:0] req_csr_addr = 12'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] req_pc = 32'h0;
    logic [3:0]  req_irq_code = 4'h0;
    logic        rsp_valid, rsp_rd_we, rsp_redirect, rsp_trapped, err;
    logic [31:0] rsp_rd_value, rsp_next_pc;
    logic        csr_available;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr_exception;
    logic [31:0] csr_write_value;
    logic [31:0] csr_read_value = 32'h0;
    logic        csr_busy = 1'b0;
    logic        csr_fault = 1'b0;

    csr_requester #(.WATCHDOG_CYCLES(8), .ILLEGAL_CODE(4'd2)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_csr_op(req_csr_op), .req_csr_addr(req_csr_addr), .req_wdata(req_wdata),
        .req_pc(req_pc), .req_irq_code(req_irq_code),
        .rsp_valid(rsp_valid), .rsp_rd_we(rsp_rd_we), .rsp_rd_value(rsp_rd_value),
        .rsp_redirect(rsp_redirect), .rsp_next_pc(rsp_next_pc), .rsp_trapped(rsp_trapped),
        .err(err), .csr_available(csr_available), .csr_op(csr_op),
        .csr_addr_exception(csr_addr_exception), .csr_write_value(csr_write_value),
        .csr_read_value(csr_read_value), .csr_busy(csr_busy), .csr_fault(csr_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd_we;
        logic [31:0] rd;
        logic        redirect;
        logic [31:0] npc;
        logic        trapped;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] val;
        logic [31:0] rd;
        logic        fault;
    } txn_t;

    rsp_t rq[$];
    txn_t tq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic resp_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the head of the queue.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (rq.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = rq.pop_front();
                chk("rsp_cycle", cyc, e.cyc);
                chk("rsp_rd_we", {31'b0, rsp_rd_we}, {31'b0, e.rd_we});
                chk("rsp_redirect", {31'b0, rsp_redirect}, {31'b0, e.redirect});
                chk("rsp_trapped", {31'b0, rsp_trapped}, {31'b0, e.trapped});
                chk("rsp_next_pc", rsp_next_pc, e.npc);
                if (e.rd_we) chk("rsp_rd_value", rsp_rd_value, e.rd);
            end
        end
    end

    // Responder: raises busy one cycle after seeing csr_available, holds it one cycle.
    logic seen_avail = 1'b0;
    logic served = 1'b0;
    logic [31:0] pend_rd = 32'h0;
    logic pend_fault = 1'b0;

    always @(negedge clk) seen_avail = csr_available;

    always @(posedge clk) begin
        #1;
        if (csr_busy) begin
            csr_busy       = 1'b0;
            served         = 1'b1;
            csr_read_value = pend_rd;
            csr_fault      = pend_fault;
        end else if (resp_en && seen_avail && !served) begin
            if (tq.size() == 0) begin
                chk("unexpected_csr_op", 32'd1, 32'd0);
                pend_rd    = 32'h0;
                pend_fault = 1'b0;
            end else begin
                txn_t t;
                t = tq.pop_front();
                chk("csr_op", {29'b0, csr_op}, {29'b0, t.op});
                chk("csr_addr", {20'b0, csr_addr_exception}, {20'b0, t.addr});
                chk("csr_value", csr_write_value, t.val);
                pend_rd    = t.rd;
                pend_fault = t.fault;
            end
            csr_busy = 1'b1;
        end else if (!seen_avail) begin
            served = 1'b0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [2:0] kind, input logic [1:0] cop, input logic [11:0] a,
                         input logic [31:0] wd, input logic [31:0] pc, input logic [3:0] irq,
                         input int lat, input rsp_t r, input bit hold);
        int acc;
        wait_ready();
        req_valid = 1'b1; req_kind = kind; req_csr_op = cop; req_csr_addr = a;
        req_wdata = wd; req_pc = pc; req_irq_code = irq;
        acc = cyc + 1;
        if (lat > 0) begin
            r.cyc = acc + lat;
            rq.push_back(r);
        end
        @(negedge clk);
        if (hold) begin
            req_kind = 3'b001; req_pc = 32'hDEAD0000; req_csr_addr = 12'hFFF;
        end else begin
            req_valid = 1'b0;
        end
        wait_ready();
        req_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rsp_t none;
        int acc;
        none = '{rd_we: 1'b0, rd: 32'h0, redirect: 1'b0, npc: 32'h0, trapped: 1'b0, cyc: 0};

        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_available", {31'b0, csr_available}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_csr_op", {29'b0, csr_op}, 32'd0);
        chk("rst_csr_addr", {20'b0, csr_addr_exception}, 32'd0);
        chk("rst_csr_value", csr_write_value, 32'd0);
        chk("rst_next_pc", rsp_next_pc, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // CSRRW with req_valid held high (junk fields) while busy.
        tq.push_back('{op: 3'b101, addr: 12'h300, val: 32'h8, rd: 32'h80, fault: 1'b0});
        issue(3'b000, 2'b01, 12'h300, 32'h8, 32'h100, 4'h0, 3,
              '{rd_we: 1'b1, rd: 32'h80, redirect: 1'b0, npc: 32'h104, trapped: 1'b0, cyc: 0}, 1'b1);

        // Faulting CSRRW becomes an illegal-instruction trap.
        tq.push_back('{op: 3'b101, addr: 12'h341, val: 32'h1, rd: 32'h0, fault: 1'b1});
        tq.push_back('{op: 3'b000, addr: 12'h002, val: 32'h100, rd: 32'h10, fault: 1'b0});
        issue(3'b000, 2'b01, 12'h341, 32'h1, 32'h100, 4'h0, 7,
              '{rd_we: 1'b0, rd: 32'h0, redirect: 1'b1, npc: 32'h10, trapped: 1'b1, cyc: 0}, 1'b0);

        tq.push_back('{op: 3'b000, addr: 12'h01B, val: 32'h200, rd: 32'h10, fault: 1'b0});
        issue(3'b100, 2'b00, 12'h0, 32'h0, 32'h200, 4'd11, 3,
              '{rd_we: 1'b0, rd: 32'h0, redirect: 1'b1, npc: 32'h10, trapped: 1'b1, cyc: 0}, 1'b0);

        tq.push_back('{op: 3'b001, addr: 12'h000, val: 32'h0, rd: 32'h203, fault: 1'b0});
        issue(3'b001, 2'b00, 12'h0, 32'h0, 32'h300, 4'h0, 3,
              '{rd_we: 1'b0, rd: 32'h0, redirect: 1'b1, npc: 32'h200, trapped: 1'b0, cyc: 0}, 1'b0);

        tq.push_back('{op: 3'b000, addr: 12'h00B, val: 32'h400, rd: 32'h13, fault: 1'b0});
        issue(3'b010, 2'b00, 12'h0, 32'h0, 32'h400, 4'h0, 3,
              '{rd_we: 1'b0, rd: 32'h0, redirect: 1'b1, npc: 32'h10, trapped: 1'b1, cyc: 0}, 1'b0);

        tq.push_back('{op: 3'b000, addr: 12'h003, val: 32'h404, rd: 32'h22, fault: 1'b0});
        issue(3'b011, 2'b00, 12'h0, 32'h0, 32'h404, 4'h0, 3,
              '{rd_we: 1'b0, rd: 32'h0, redirect: 1'b1, npc: 32'h20, trapped: 1'b1, cyc: 0}, 1'b0);

        // CSRRS at the top of the address space: next_pc wraps to 0.
        tq.push_back('{op: 3'b110, addr: 12'h305, val: 32'hFF, rd: 32'h1234, fault: 1'b0});
        issue(3'b000, 2'b10, 12'h305, 32'hFF, 32'hFFFFFFFC, 4'h0, 3,
              '{rd_we: 1'b1, rd: 32'h1234, redirect: 1'b0, npc: 32'h0, trapped: 1'b0, cyc: 0}, 1'b0);

        tq.push_back('{op: 3'b111, addr: 12'h340, val: 32'h3, rd: 32'hAAAA5555, fault: 1'b0});
        issue(3'b000, 2'b11, 12'h340, 32'h3, 32'h700, 4'h0, 3,
              '{rd_we: 1'b1, rd: 32'hAAAA5555, redirect: 1'b0, npc: 32'h704, trapped: 1'b0, cyc: 0}, 1'b0);

        tq.push_back('{op: 3'b000, addr: 12'h002, val: 32'h500, rd: 32'h30, fault: 1'b0});
        issue(3'b000, 2'b00, 12'h123, 32'h5, 32'h500, 4'h0, 3,
              '{rd_we: 1'b0, rd: 32'h0, redirect: 1'b1, npc: 32'h30, trapped: 1'b1, cyc: 0}, 1'b0);

        tq.push_back('{op: 3'b000, addr: 12'h002, val: 32'h600, rd: 32'h41, fault: 1'b0});
        issue(3'b101, 2'b01, 12'h123, 32'h5, 32'h600, 4'h0, 3,
              '{rd_we: 1'b0, rd: 32'h0, redirect: 1'b1, npc: 32'h40, trapped: 1'b1, cyc: 0}, 1'b0);

        chk("err_clean", {31'b0, err}, 32'd0);

        // Faulting MRET: response still issued, err set.
        tq.push_back('{op: 3'b001, addr: 12'h000, val: 32'h0, rd: 32'h204, fault: 1'b1});
        issue(3'b001, 2'b00, 12'h0, 32'h0, 32'h800, 4'h0, 3,
              '{rd_we: 1'b0, rd: 32'h0, redirect: 1'b1, npc: 32'h204, trapped: 1'b0, cyc: 0}, 1'b0);
        chk("err_mret_fault", {31'b0, err}, 32'd1);
        pulse_reset();
        chk("err_after_reset", {31'b0, err}, 32'd0);

        // Watchdog: responder silent.
        resp_en = 1'b0;
        wait_ready();
        req_valid = 1'b1; req_kind = 3'b000; req_csr_op = 2'b01; req_csr_addr = 12'h300;
        req_wdata = 32'h1; req_pc = 32'h900;
        acc = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (cyc < acc + 7) @(negedge clk);
        chk("wdog_err_before", {31'b0, err}, 32'd0);
        chk("wdog_avail_before", {31'b0, csr_available}, 32'd1);
        @(negedge clk);
        chk("wdog_err", {31'b0, err}, 32'd1);
        chk("wdog_avail", {31'b0, csr_available}, 32'd0);
        chk("wdog_ready", {31'b0, req_ready}, 32'd1);
        repeat (5) @(negedge clk);
        chk("wdog_err_sticky", {31'b0, err}, 32'd1);
        resp_en = 1'b1;
        pulse_reset();

        // Reset while in WAIT.
        tq.push_back('{op: 3'b101, addr: 12'h300, val: 32'h55, rd: 32'h1, fault: 1'b0});
        wait_ready();
        req_valid = 1'b1; req_kind = 3'b000; req_csr_op = 2'b01; req_csr_addr = 12'h300;
        req_wdata = 32'h55; req_pc = 32'hA00;
        acc = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (cyc < acc + 2) @(negedge clk);
        chk("wait_avail", {31'b0, csr_available}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rstw_avail", {31'b0, csr_available}, 32'd0);
        chk("rstw_ready", {31'b0, req_ready}, 32'd1);
        chk("rstw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        chk("rsp_queue_empty", rq.size(), 32'd0);
        chk("csr_queue_empty", tq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/csr_requester.md
CSR_REQUESTER -- requirements
Module: csr_requester

Interface
REQ-001 Parameter WATCHDOG_CYCLES, default 8: max cycles spent in REQ or WAIT before abort.
REQ-002 Parameter ILLEGAL_CODE, default 4'd2: mcause code used when a CSR access faults.
REQ-003 clk  input  1  clock; reset_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  core request present; req_ready  output  1  high only in IDLE.
REQ-005 req_kind  input  3  000=CSR insn, 001=MRET, 010=ECALL, 011=EBREAK, 100=IRQ; others illegal.
REQ-006 req_csr_op  input  2  01=RW, 10=RS, 11=RC, 00=illegal; req_csr_addr  input  12  CSR address.
REQ-007 req_wdata  input  32  CSR operand; req_pc  input  32  PC of request; req_irq_code  input  4  interrupt cause.
REQ-008 rsp_valid  output  1  one-cycle result pulse.
REQ-009 rsp_rd_we  output  1  write rd; rsp_rd_value  output  32  rd data.
REQ-010 rsp_redirect  output  1  PC change; rsp_next_pc  output  32  next PC; rsp_trapped  output  1  trap taken.
REQ-011 err  output  1  sticky protocol error.
REQ-012 csr_available  output  1; csr_op  output  3; csr_addr_exception  output  12; csr_write_value  output  32.
REQ-013 csr_read_value  input  32; csr_busy  input  1; csr_fault  input  1.

Function
REQ-014 States IDLE, REQ, WAIT, REL; all outputs registered.
REQ-015 IDLE: req_valid & req_ready accepts; all req_* fields latched; csr_* driven from latched request; next REQ.
REQ-016 Mapping: CSR -> op {1,req_csr_op}, addr req_csr_addr, value req_wdata; MRET -> op 001, addr 0, value 0.
REQ-017 ECALL -> op 000, addr 12'h00B, value req_pc; EBREAK -> addr 12'h003; IRQ -> addr {7'b0,1'b1,req_irq_code}, value req_pc.
REQ-018 CSR with req_csr_op=00, or undefined req_kind -> directly issue trap op 000, addr {8'b0,ILLEGAL_CODE}, value req_pc.
REQ-019 REQ: csr_available=1; csr_busy=1 -> WAIT.
REQ-020 WAIT: csr_available=1; csr_busy=0 -> capture csr_read_value, csr_fault; next REL.
REQ-021 REL: csr_available=0 exactly one cycle; op/addr/value stable throughout REQ and WAIT.
REQ-022 REL after faulting CSR insn: load illegal trap op (REQ-018 encoding), next REQ; no rsp_valid.
REQ-023 Otherwise REL: rsp_valid=1 for that cycle, next IDLE.
REQ-024 CSR success: rd_we=1, rd_value=captured read, redirect=0, next_pc=req_pc+4 (mod 2^32), trapped=0.
REQ-025 MRET: rd_we=0, redirect=1, next_pc={read[31:2],2'b00}, trapped=0.
REQ-026 Trap (ECALL/EBREAK/IRQ/illegal): rd_we=0, redirect=1, next_pc={read[31:2],2'b00}, trapped=1.
REQ-027 csr_fault on MRET or trap op: err=1, response still issued per REQ-025/026; no retry (no loop).
REQ-028 Latency, acceptance at edge N: rsp_valid in cycle after edge N+3; faulting CSR insn: after edge N+7.
REQ-029 Watchdog: counter cleared on REQ/WAIT entry; reaching WATCHDOG_CYCLES -> err=1, csr_available=0, IDLE, no response.
REQ-030 req_valid ignored outside IDLE; fields sampled only at acceptance.

Reset
REQ-031 reset_n=0 at clock edge: state IDLE, req_ready=1, all other outputs 0, err=0, counters 0.
REQ-032 Reset mid-operation aborts immediately; no rsp_valid; csr_available low next cycle.

Verification
REQ-033 CSRRW 0x300, wdata 0x08, pc 0x100, responder read 0x80 -> rsp at N+3: rd_we=1, rd 0x80, next_pc 0x104.
REQ-034 CSRRW 0x341 wdata 1, responder faults, trap read 0x10 -> second op 000 addr 0x002 value 0x100; rsp at N+7: redirect, next_pc 0x10, trapped=1.
REQ-035 IRQ code 11, pc 0x200 -> addr 0x01B, value 0x200; next_pc 0x10, trapped=1, rd_we=0.
REQ-036 MRET, responder read 0x203 -> redirect, next_pc 0x200, trapped=0.
REQ-037 Responder never raises busy -> err=1 after 8 cycles in REQ, IDLE, no rsp_valid; err held until reset.
REQ-038 reset_n low during WAIT -> next cycle csr_available=0, req_ready=1, no rsp_valid.
